change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16: max cycles a coin is offered without coin_ack before abort, legal range 2-255.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1: request to dispense `amount`; sampled only when not busy.
REQ-005 SHALL have port amount, input, 8: change value in cents, unsigned, 0-255.
REQ-006 SHALL have port coin_ack, input, 1: coin mechanism accepted the offered coin this cycle.
REQ-007 SHALL have port coin_valid, output, 1: a coin is offered.
REQ-008 SHALL have ports quarter_out, dime_out, nickel_out and penny_out, each output, 1: the offered denomination, one-hot, all 0 when coin_valid=0.
REQ-009 SHALL have port remaining, output, 8: cents still to dispense.
REQ-010 SHALL have port busy, output, 1: high in OFFER state.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a transaction completes.
REQ-012 SHALL have port error, output, 1: sticky timeout flag.

Function
REQ-013 SHALL use states IDLE, OFFER, DONE, ERROR.
REQ-014 In IDLE or ERROR with start=1 and amount>0: SHALL load remaining<=amount, clear error and the timeout counter, and go to OFFER.
REQ-015 In IDLE or ERROR with start=1 and amount=0: SHALL go to DONE with no coin offered and clear error.
REQ-016 start while in OFFER or DONE SHALL be ignored; amount SHALL not be re-sampled.
REQ-017 In OFFER: coin_valid=1, and the denomination SHALL be greedy from registered remaining: quarter if >=25, else dime if >=10, else nickel if >=5, else penny.
REQ-018 Offered coin and coin_valid SHALL remain stable until coin_ack is seen or timeout occurs.
REQ-019 On coin_valid&coin_ack at a posedge: SHALL update remaining<=remaining-value (25/10/5/1) and reset the timeout counter; if the result is 0, go to DONE, else stay in OFFER.
REQ-020 Dispensing SHALL use one coin per accepted handshake, minimum one cycle per coin; back-to-back acks are allowed.
REQ-021 coin_ack while coin_valid=0 SHALL be ignored.
REQ-022 The timeout counter SHALL increment each OFFER cycle without ack; on reaching ACK_TIMEOUT, SHALL go to ERROR, set error=1, and hold remaining (undispensed cents).
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 ERROR SHALL have coin_valid=0 and busy=0; error SHALL hold until start or reset.
REQ-025 remaining SHALL never underflow; greedy selection guarantees value<=remaining.

Reset
REQ-026 reset=0 at a posedge SHALL force IDLE, remaining=0, coin_valid=0, all coin outputs=0, busy=0, done=0, error=0, timeout counter=0, regardless of state; it overrides start and coin_ack in the same cycle.
REQ-027 Reset mid-transaction SHALL abandon the remaining change; no done pulse is produced.

Configuration
REQ-028 With macro CHANGE_DISPENSER_COINCNT_EN defined: SHALL add output coin_count, 8 bits.
- Cleared on reset and on accepted start.
- Increments on each coin handshake.
- Holds after DONE/ERROR until next start.
REQ-029 Without CHANGE_DISPENSER_COINCNT_EN: the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 start, amount=41, ack every cycle -> coins Q,D,N,P on 4 consecutive cycles; remaining 41->16->6->1->0; done pulse on the next cycle.
REQ-031 amount=255, ack always high -> 10 quarters then 1 nickel (11 coins); done once; coin_count=11 when enabled.
REQ-032 amount=0 -> no coin_valid; done pulse 1 cycle after start.
REQ-033 amount=30, ack withheld after the first quarter, ACK_TIMEOUT=16 -> after 16 offer cycles: error=1, remaining=5, coin_valid=0; then start with amount=7 -> error=0 and coins N,P,P.
REQ-034 amount=60, reset=0 after 1 coin -> next cycle all outputs at reset values; no done; a start while busy (amount=99) is ignored throughout.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy change dispenser: offers quarters/dimes/nickels/pennies one at a time under a valid/ack handshake.
// Defining CHANGE_DISPENSER_COINCNT_EN adds the coin_count output.
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic       quarter_out,
    output logic       dime_out,
    output logic       nickel_out,
    output logic       penny_out,
    output logic [7:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       error
`ifdef CHANGE_DISPENSER_COINCNT_EN
    ,
    output logic [7:0] coin_count
`endif
);

    typedef enum logic [1:0] {IDLE, OFFER, DONE, ERROR} state_t;

    // Timer value on the last cycle a coin may sit unacknowledged.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_remaining;
    logic [7:0] r_timer;
    logic       r_error;
    logic [7:0] w_coin_value;
    logic       w_offer;
    logic       w_accept;
    logic       w_timeout;
    logic       w_start;

    assign w_offer   = (r_state == OFFER);
    assign w_accept  = w_offer && coin_ack;
    assign w_timeout = w_offer && !coin_ack && (r_timer == TIMEOUT_LAST);
    assign w_start   = start && ((r_state == IDLE) || (r_state == ERROR));

    // Greedy pick from the registered balance, so the offer cannot change until the balance does.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        w_coin_value = 8'd1;
        quarter_out  = 1'b0;
        dime_out     = 1'b0;
        nickel_out   = 1'b0;
        penny_out    = 1'b0;
        if (r_remaining >= 8'd25) begin
            w_coin_value = 8'd25;
            quarter_out  = w_offer;
        end else if (r_remaining >= 8'd10) begin
            w_coin_value = 8'd10;
            dime_out     = w_offer;
        end else if (r_remaining >= 8'd5) begin
            w_coin_value = 8'd5;
            nickel_out   = w_offer;
        end else begin
            penny_out    = w_offer;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, ERROR: begin
                if (w_start) w_next_state = (amount != 8'd0) ? OFFER : DONE;
            end
            OFFER: begin
                if (w_accept) begin
                    if (r_remaining == w_coin_value) w_next_state = DONE;
                end else if (w_timeout) begin
                    w_next_state = ERROR;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_remaining <= 8'd0;
            r_timer     <= 8'd0;
            r_error     <= 1'b0;
        end else if (w_start) begin
            r_remaining <= amount;
            r_timer     <= 8'd0;
            r_error     <= 1'b0;
        end else if (w_accept) begin
            r_remaining <= r_remaining - w_coin_value;
            r_timer     <= 8'd0;
        end else if (w_timeout) begin
            r_timer     <= 8'd0;
            r_error     <= 1'b1;
        end else if (w_offer) begin
            r_timer     <= r_timer + 8'd1;
        end
    end

`ifdef CHANGE_DISPENSER_COINCNT_EN
    logic [7:0] r_coin_count;

    always_ff @(posedge clk) begin
        if (!reset)        r_coin_count <= 8'd0;
        else if (w_start)  r_coin_count <= 8'd0;
        else if (w_accept) r_coin_count <= r_coin_count + 8'd1;
    end

    assign coin_count = r_coin_count;
`endif

    assign coin_valid = w_offer;
    assign busy       = w_offer;
    assign done       = (r_state == DONE);
    assign error      = r_error;
    assign remaining  = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed transactions, a cycle-level reference model compared every
// falling edge, and hand-computed literal expectations at key points.
module tb_change_dispenser;

    localparam int TO = 16;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] amount;
    logic       coin_ack;
    logic       coin_valid;
    logic       quarter_out;
    logic       dime_out;
    logic       nickel_out;
    logic       penny_out;
    logic [7:0] remaining;
    logic       busy;
    logic       done;
    logic       error;
`ifdef CHANGE_DISPENSER_COINCNT_EN
    logic [7:0] coin_count;
`endif

    change_dispenser #(.ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .coin_ack    (coin_ack),
        .coin_valid  (coin_valid),
        .quarter_out (quarter_out),
        .dime_out    (dime_out),
        .nickel_out  (nickel_out),
        .penny_out   (penny_out),
        .remaining   (remaining),
        .busy        (busy),
        .done        (done),
        .error       (error)
`ifdef CHANGE_DISPENSER_COINCNT_EN
        ,
        .coin_count  (coin_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    logic [15:0] dut_vec;
    assign dut_vec = {coin_valid, quarter_out, dime_out, nickel_out, penny_out,
                      busy, done, error, remaining};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // coin = {coin_valid, Q, D, N, P}; flags = {busy, done, error}
    task automatic expect_out(input string name, input logic [4:0] coin, input logic [2:0] flags,
                              input int rem);
        check(name, dut_vec, {coin, flags, 8'(rem)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_of(input int rem);
        if (rem >= 25) return 25;
        if (rem >= 10) return 10;
        if (rem >= 5)  return 5;
        return 1;
    endfunction

    // Reference model: a transaction is either offering coins, finishing (one done cycle), or idle.
    int m_rem  = 0;
    int m_wait = 0;
    int m_cnt  = 0;
    bit m_off  = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    always @(posedge clk) begin : model
        int rem, wt, cnt;
        bit off, dn, err;
        rem = m_rem; wt = m_wait; cnt = m_cnt; off = m_off; dn = m_done; err = m_err;
        if (!reset) begin
            rem = 0; wt = 0; cnt = 0; off = 0; dn = 0; err = 0;
        end else if (m_off) begin
            if (coin_ack) begin
                rem = m_rem - coin_of(m_rem);
                wt  = 0;
                cnt = m_cnt + 1;
                if (rem == 0) begin off = 0; dn = 1; end
            end else begin
                wt = m_wait + 1;
                if (wt == TO) begin off = 0; err = 1; wt = 0; end
            end
        end else if (m_done) begin
            dn = 0;
        end else if (start) begin
            rem = int'(amount); wt = 0; cnt = 0; err = 0;
            if (amount == 8'd0) dn = 1;
            else                off = 1;
        end
        m_rem <= rem; m_wait <= wt; m_cnt <= cnt; m_off <= off; m_done <= dn; m_err <= err;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int c;
            c = coin_of(m_rem);
            check("model_outputs", dut_vec,
                  {m_off, m_off && c == 25, m_off && c == 10, m_off && c == 5, m_off && c == 1,
                   m_off, m_done, m_err, 8'(m_rem)});
`ifdef CHANGE_DISPENSER_COINCNT_EN
            check("model_coin_count", {8'd0, coin_count}, 16'(m_cnt));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nq, nn, nc, ndone;
        reset = 1'b0; start = 1'b0; amount = 8'd0; coin_ack = 1'b0;

        // reset state
        tick();
        cmp_en = 1'b1;
        expect_out("reset_state", 5'b00000, 3'b000, 0);
        tick();
        reset = 1'b1;
        tick();

        // 41 cents, ack every cycle: Q,D,N,P then done; start during OFFER/DONE ignored
        start = 1'b1; amount = 8'd41; coin_ack = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t41_quarter", 5'b11000, 3'b100, 41);
        tick();
        expect_out("t41_dime", 5'b10100, 3'b100, 16);
        tick();
        expect_out("t41_nickel", 5'b10010, 3'b100, 6);
        start = 1'b1; amount = 8'd50;
        tick();
        expect_out("t41_penny", 5'b10001, 3'b100, 1);
        tick();
        expect_out("t41_done", 5'b00000, 3'b010, 0);
        tick();
        expect_out("t41_idle_start_ignored", 5'b00000, 3'b000, 0);
        start = 1'b0; coin_ack = 1'b0;
        tick();

        // 255 cents, ack always high: 10 quarters + 1 nickel
        start = 1'b1; amount = 8'd255; coin_ack = 1'b1;
        tick();
        start = 1'b0;
        nq = 0; nn = 0; nc = 0; ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (coin_valid) begin
                nc++;
                if (quarter_out) nq++;
                if (nickel_out)  nn++;
            end
            if (done) ndone++;
            tick();
        end
        check("t255_quarters", 16'(nq), 16'd10);
        check("t255_nickels", 16'(nn), 16'd1);
        check("t255_coins", 16'(nc), 16'd11);
        check("t255_done_pulses", 16'(ndone), 16'd1);
`ifdef CHANGE_DISPENSER_COINCNT_EN
        check("t255_coin_count", {8'd0, coin_count}, 16'd11);
`endif
        coin_ack = 1'b0;

        // zero amount: done one cycle after start, no coin
        start = 1'b1; amount = 8'd0;
        tick();
        start = 1'b0;
        expect_out("t0_done", 5'b00000, 3'b010, 0);
        tick();
        expect_out("t0_idle", 5'b00000, 3'b000, 0);

        // 30 cents, ack withheld after first quarter -> timeout, then recover with 7 cents
        start = 1'b1; amount = 8'd30; coin_ack = 1'b1;
        tick();
        start = 1'b0;
        expect_out("t30_quarter", 5'b11000, 3'b100, 30);
        tick();
        coin_ack = 1'b0;
        expect_out("t30_nickel", 5'b10010, 3'b100, 5);
        repeat (TO - 1) tick();
        expect_out("t30_last_offer", 5'b10010, 3'b100, 5);
        tick();
        expect_out("t30_timeout", 5'b00000, 3'b001, 5);
        coin_ack = 1'b1;
        repeat (2) tick();
        expect_out("t30_error_sticky", 5'b00000, 3'b001, 5);
        start = 1'b1; amount = 8'd7;
        tick();
        start = 1'b0;
        expect_out("t7_nickel", 5'b10010, 3'b100, 7);
        tick();
        expect_out("t7_penny1", 5'b10001, 3'b100, 2);
        tick();
        expect_out("t7_penny2", 5'b10001, 3'b100, 1);
        tick();
        expect_out("t7_done", 5'b00000, 3'b010, 0);
        coin_ack = 1'b0;
        tick();

        // 60 cents, reset after first coin; start while busy ignored
        start = 1'b1; amount = 8'd60; coin_ack = 1'b1;
        tick();
        expect_out("t60_quarter", 5'b11000, 3'b100, 60);
        amount = 8'd99;
        tick();
        expect_out("t60_busy_start_ignored", 5'b11000, 3'b100, 35);
        reset = 1'b0;
        tick();
        expect_out("t60_reset", 5'b00000, 3'b000, 0);
`ifdef CHANGE_DISPENSER_COINCNT_EN
        check("t60_reset_coin_count", {8'd0, coin_count}, 16'd0);
`endif
        reset = 1'b1; start = 1'b0; coin_ack = 1'b0;
        tick();
        expect_out("t60_no_done", 5'b00000, 3'b000, 0);
        repeat (3) tick();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
